// File: rtl/alu_driver.sv
// Command sequencer for the 3-bit ALU: buffers commands in a FIFO, drives the ALU,
// captures each result into a response port and checks it against a reference model.
module alu_driver #(
   parameter int DEPTH   = 4,
   parameter int ALU_LAT = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [2:0] cmd_a,
   input  logic [2:0] cmd_b,
   input  logic [2:0] cmd_op,
   output logic [2:0] alu_a,
   output logic [2:0] alu_b,
   output logic [2:0] alu_op,
   input  logic [3:0] alu_result,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [3:0] rsp_result,
   output logic [2:0] rsp_op,
   output logic       rsp_mismatch,
   output logic [7:0] err_count,
   output logic       busy
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state_q, state_d;
   logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [8:0]  mem_q [DEPTH];
   logic [2:0]  cnt_q, cnt_d;
   logic [3:0]  exp_q, exp_d;
   logic [2:0]  alu_a_q, alu_a_d, alu_b_q, alu_b_d, alu_op_q, alu_op_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [3:0]  rsp_result_q, rsp_result_d;
   logic [2:0]  rsp_op_q, rsp_op_d;
   logic        rsp_mm_q, rsp_mm_d;
   logic [7:0]  err_q, err_d;

   logic       empty, full, push, mm;
   logic [8:0] head;

   function automatic logic [3:0] ref_model(input logic [2:0] a, input logic [2:0] b,
                                            input logic [2:0] op);
      logic [3:0] ax, bx;
      ax = {1'b0, a};
      bx = {1'b0, b};
      case (op)
         3'b000:  ref_model = ax + bx;
         3'b001:  ref_model = ax - bx;
         3'b010:  ref_model = ax & bx;
         3'b011:  ref_model = ax | bx;
         3'b100:  ref_model = ax ^ bx;
         3'b101:  ref_model = {1'b0, ~a};
         3'b110:  ref_model = {a, 1'b0};
         default: ref_model = (a > b) ? 4'd1 : 4'd0;
      endcase
   endfunction

   assign empty = (wptr_q == rptr_q);
   assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign push  = cmd_valid && !full;
   assign head  = mem_q[rptr_q[AW-1:0]];
   assign mm    = (alu_result != exp_q);

   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q[AW-1:0]] <= {cmd_op, cmd_a, cmd_b};
   end

   always_comb begin
      state_d      = state_q;
      wptr_d       = push ? wptr_q + PTR_ONE : wptr_q;
      rptr_d       = rptr_q;
      cnt_d        = cnt_q;
      exp_d        = exp_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_op_d     = alu_op_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_result_d = rsp_result_q;
      rsp_op_d     = rsp_op_q;
      rsp_mm_d     = rsp_mm_q;
      err_d        = err_q;
      case (state_q)
         IDLE: begin
            if (!empty) begin
               rptr_d   = rptr_q + PTR_ONE;
               alu_op_d = head[8:6];
               alu_a_d  = head[5:3];
               alu_b_d  = head[2:0];
               cnt_d    = ALU_LAT[2:0];
               exp_d    = ref_model(head[5:3], head[2:0], head[8:6]);
               state_d  = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q != 3'd0) begin
               cnt_d = cnt_q - 3'd1;
            end else begin
               rsp_result_d = alu_result;
               rsp_mm_d     = mm;
               rsp_op_d     = alu_op_q;
               rsp_valid_d  = 1'b1;
               // Saturate rather than wrap so a long failing run stays visibly bad.
               if (mm && err_q != 8'hFF) err_d = err_q + 8'd1;
               state_d = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         wptr_q       <= '0;
         rptr_q       <= '0;
         cnt_q        <= '0;
         exp_q        <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_op_q     <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_result_q <= '0;
         rsp_op_q     <= '0;
         rsp_mm_q     <= 1'b0;
         err_q        <= '0;
      end else begin
         state_q      <= state_d;
         wptr_q       <= wptr_d;
         rptr_q       <= rptr_d;
         cnt_q        <= cnt_d;
         exp_q        <= exp_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_op_q     <= alu_op_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_result_q <= rsp_result_d;
         rsp_op_q     <= rsp_op_d;
         rsp_mm_q     <= rsp_mm_d;
         err_q        <= err_d;
      end
   end

   assign cmd_ready    = !full;
   assign alu_a        = alu_a_q;
   assign alu_b        = alu_b_q;
   assign alu_op       = alu_op_q;
   assign rsp_valid    = rsp_valid_q;
   assign rsp_result   = rsp_result_q;
   assign rsp_op       = rsp_op_q;
   assign rsp_mismatch = rsp_mm_q;
   assign err_count    = err_q;
   assign busy         = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_alu_driver.sv
// Directed bench for alu_driver with a registered ALU model (ALU_LAT=1, DEPTH=4).
module tb_alu_driver;

   logic       clk, rst;
   logic       cmd_valid, cmd_ready;
   logic [2:0] cmd_a, cmd_b, cmd_op;
   logic [2:0] alu_a, alu_b, alu_op;
   logic [3:0] alu_result;
   logic       rsp_valid, rsp_ready;
   logic [3:0] rsp_result;
   logic [2:0] rsp_op;
   logic       rsp_mismatch;
   logic [7:0] err_count;
   logic       busy;
   logic       corrupt;

   int ntests = 0;
   int nfail  = 0;

   alu_driver #(.DEPTH(4), .ALU_LAT(1)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_result(alu_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_op(rsp_op),
      .rsp_mismatch(rsp_mismatch), .err_count(err_count), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Registered ALU stand-in; optionally corrupts every result by +1.
   function automatic logic [3:0] alu_fn(input logic [2:0] a, input logic [2:0] b,
                                         input logic [2:0] op);
      int ia, ib, r;
      ia = int'(a);
      ib = int'(b);
      case (op)
         3'd0: r = ia + ib;
         3'd1: r = (ia - ib + 16) % 16;
         3'd2: r = ia & ib;
         3'd3: r = ia | ib;
         3'd4: r = ia ^ ib;
         3'd5: r = 7 - ia;
         3'd6: r = ia * 2;
         default: r = (ia > ib) ? 1 : 0;
      endcase
      return r[3:0];
   endfunction

   always @(posedge clk) alu_result <= alu_fn(alu_a, alu_b, alu_op) + {3'b000, corrupt};

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [2:0] a, input logic [2:0] b, input logic [2:0] op);
      cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(input string tag);
      int n = 0;
      while (!rsp_valid && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_valid"}, rsp_valid, 1);
   endtask

   task automatic run_cmd(input string tag, input logic [2:0] a, input logic [2:0] b,
                          input logic [2:0] op, input logic [3:0] exp);
      push(a, b, op);
      wait_rsp(tag);
      chk({tag, "_result"}, rsp_result, exp);
      chk({tag, "_op"}, rsp_op, op);
      chk({tag, "_mm"}, rsp_mismatch, 0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   logic [2:0] ba [6];
   logic [2:0] bb [6];
   logic [2:0] bo [6];
   logic [3:0] be [6];

   initial begin
      int cnt;
      int r;
      rst = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0;
      rsp_ready = 1'b0; corrupt = 1'b0;

      // reset
      #2 rst = 1'b1;
      #1;
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_alu", {alu_a, alu_b, alu_op}, 0);
      chk("rst_rsp", {rsp_result, rsp_op, rsp_mismatch}, 0);
      chk("rst_err", err_count, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) tick();
      chk("idle_rsp_valid", rsp_valid, 0);
      chk("idle_busy", busy, 0);
      chk("idle_cmd_ready", cmd_ready, 1);

      // basic add with exact latency
      push(3'd1, 3'd5, 3'd0);
      chk("add_busy_P", busy, 1);
      chk("add_alu_a_P", alu_a, 0);
      tick();
      chk("add_alu_P1", {alu_a, alu_b, alu_op}, {3'd1, 3'd5, 3'd0});
      chk("add_valid_P1", rsp_valid, 0);
      tick();
      chk("add_valid_P2", rsp_valid, 0);
      tick();
      chk("add_valid_P3", rsp_valid, 1);
      chk("add_result", rsp_result, 4'd6);
      chk("add_mm", rsp_mismatch, 0);
      tick();
      chk("add_hold_valid", rsp_valid, 1);
      chk("add_hold_result", rsp_result, 4'd6);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("add_hs_valid", rsp_valid, 0);
      tick();
      chk("add_done_busy", busy, 0);

      // assorted ops
      run_cmd("sub_wrap", 3'd5, 3'd7, 3'd1, 4'hE);
      run_cmd("gt", 3'd6, 3'd2, 3'd7, 4'd1);
      run_cmd("not", 3'd3, 3'd0, 3'd5, 4'd4);
      run_cmd("shl", 3'd5, 3'd0, 3'd6, 4'hA);
      run_cmd("add_carry", 3'd7, 3'd7, 3'd0, 4'hE);
      run_cmd("xor", 3'd6, 3'd3, 3'd4, 4'd5);

      // backpressure / full FIFO
      ba[0] = 3'd1; bb[0] = 3'd1; bo[0] = 3'd0; be[0] = 4'd2;
      ba[1] = 3'd3; bb[1] = 3'd4; bo[1] = 3'd0; be[1] = 4'd7;
      ba[2] = 3'd7; bb[2] = 3'd1; bo[2] = 3'd1; be[2] = 4'd6;
      ba[3] = 3'd5; bb[3] = 3'd3; bo[3] = 3'd2; be[3] = 4'd1;
      ba[4] = 3'd2; bb[4] = 3'd0; bo[4] = 3'd6; be[4] = 4'd4;
      ba[5] = 3'd7; bb[5] = 3'd0; bo[5] = 3'd5; be[5] = 4'd0;
      for (int i = 0; i < 5; i++) begin
         cmd_a = ba[i]; cmd_b = bb[i]; cmd_op = bo[i]; cmd_valid = 1'b1;
         tick();
      end
      chk("full_cmd_ready", cmd_ready, 0);
      cmd_a = ba[5]; cmd_b = bb[5]; cmd_op = bo[5];
      repeat (3) tick();
      chk("full_held_ready", cmd_ready, 0);
      chk("full_rsp_valid", rsp_valid, 1);
      chk("full_rsp0", rsp_result, be[0]);
      rsp_ready = 1'b1;
      tick();
      chk("full_hs_valid", rsp_valid, 0);
      cnt = 0;
      r = 0;
      while (r == 0 && cnt < 20) begin
         r = int'(cmd_ready);
         tick();
         cnt++;
      end
      cmd_valid = 1'b0;
      chk("cmd6_accepted", r, 1);
      for (int i = 1; i < 6; i++) begin
         wait_rsp($sformatf("drain%0d", i));
         chk($sformatf("drain%0d_result", i), rsp_result, be[i]);
         chk($sformatf("drain%0d_op", i), rsp_op, bo[i]);
         tick();
      end
      rsp_ready = 1'b0;
      tick();
      chk("drain_busy", busy, 0);

      // mismatch counting and saturation
      corrupt = 1'b1;
      rsp_ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         push(3'(i), 3'(i >> 3), 3'(i >> 6));
         wait_rsp("mm");
         chk("mm_flag", rsp_mismatch, 1);
         tick();
         if (i == 0)   chk("err_first", err_count, 8'd1);
         if (i == 253) chk("err_254", err_count, 8'd254);
         if (i == 254) chk("err_255", err_count, 8'd255);
      end
      chk("err_sat", err_count, 8'd255);
      corrupt = 1'b0;
      rsp_ready = 1'b0;
      tick();

      // reset while waiting with three entries queued
      push(3'd2, 3'd2, 3'd0);
      wait_rsp("pre");
      cmd_valid = 1'b1;
      cmd_a = 3'd4; cmd_b = 3'd4; cmd_op = 3'd0; tick();
      cmd_a = 3'd1; cmd_b = 3'd2; cmd_op = 3'd3; tick();
      cmd_a = 3'd3; cmd_b = 3'd3; cmd_op = 3'd3; tick();
      cmd_a = 3'd6; cmd_b = 3'd6; cmd_op = 3'd6; tick();
      cmd_valid = 1'b0;
      chk("pre_full", cmd_ready, 0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("pre_hs", rsp_valid, 0);
      tick();
      chk("pre_loaded", alu_a, 3'd4);
      chk("pre_ready", cmd_ready, 1);
      chk("pre_busy", busy, 1);
      #1 rst = 1'b1;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_ready", cmd_ready, 1);
      chk("midrst_alu", {alu_a, alu_b, alu_op}, 0);
      chk("midrst_err", err_count, 0);
      chk("midrst_valid", rsp_valid, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (rsp_valid) cnt++;
      end
      chk("post_rst_no_rsp", cnt, 0);
      chk("post_rst_busy", busy, 0);
      run_cmd("post_rst", 3'd3, 3'd2, 3'd0, 4'd5);
      chk("post_rst_err", err_count, 0);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
